// File: rtl/adc_frontend_pkg.sv
// Shared types and width helpers for the phase-current ADC front-end.
package adc_frontend_pkg;

   typedef logic [1:0] zc_state_t;

   localparam zc_state_t ZC_UNKNOWN = 2'd0;
   localparam zc_state_t ZC_POS     = 2'd1;
   localparam zc_state_t ZC_NEG     = 2'd2;

   // Corrected sample carries one extra bit so +/-(2^DATA_W - 1) is representable
   function automatic int unsigned corr_width(input int unsigned data_w);
      return data_w + 1;
   endfunction

   function automatic int unsigned sum_width(input int unsigned corr_w, input int unsigned avg_log2);
      return corr_w + avg_log2;
   endfunction

   // Symmetric clamp magnitude for the offset-corrected sample
   function automatic int unsigned sat_limit(input int unsigned data_w);
      return (1 << data_w) - 1;
   endfunction

endpackage

// File: rtl/adc_boxcar.sv
// Power-of-two boxcar filter: ring buffer, running sum and window-fill tracking.
module adc_boxcar
   import adc_frontend_pkg::*;
#(
   parameter int unsigned W        = 11,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                corr_valid,
   input  logic signed [W-1:0] corr,
   output logic signed [W-1:0] sample,
   output logic                sample_valid
);

   localparam int unsigned DEPTH = 1 << AVG_LOG2;

   generate
      if (AVG_LOG2 == 0) begin : g_bypass
         // Length-one window: register the corrected sample directly
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sample       <= '0;
               sample_valid <= 1'b0;
            end else if (corr_valid) begin
               sample       <= corr;
               sample_valid <= 1'b1;
            end
         end
      end else begin : g_avg
         localparam int unsigned SUM_W  = sum_width(W, AVG_LOG2);
         localparam int unsigned FILL_W = $clog2(DEPTH + 1);
         localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
         localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

         logic signed [W-1:0]     ring [DEPTH];
         logic [AVG_LOG2-1:0]     wr_ptr;
         logic signed [SUM_W-1:0] sum_q;
         logic signed [SUM_W-1:0] sum_c;
         logic [FILL_W-1:0]       fill_q;

         // Slot at wr_ptr holds the oldest sample; it reads zero until the window fills
         assign sum_c = sum_q + SUM_W'(corr) - SUM_W'(ring[wr_ptr]);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < int'(DEPTH); i++) ring[i] <= '0;
               wr_ptr       <= '0;
               sum_q        <= '0;
               fill_q       <= '0;
               sample       <= '0;
               sample_valid <= 1'b0;
            end else if (corr_valid) begin
               ring[wr_ptr] <= corr;
               wr_ptr       <= wr_ptr + AVG_LOG2'(1);
               sum_q        <= sum_c;
               sample       <= W'(sum_c >>> AVG_LOG2);
               if (fill_q != FILL_FULL) fill_q <= fill_q + FILL_W'(1);
               if (fill_q == FILL_LAST) sample_valid <= 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/adc_frontend.sv
// Phase-current ADC front-end: offset-binary conversion, calibration, boxcar filter,
// latched over-current trip, hysteretic zero-crossing detector and peak-magnitude hold.
module adc_frontend
   import adc_frontend_pkg::*;
#(
   parameter int unsigned DATA_W     = 10,
   parameter int unsigned AVG_LOG2   = 2,
   parameter int unsigned TRIP_COUNT = 3,
   parameter int unsigned ZC_HYST    = 16,
   parameter int unsigned ZC_HOLDOFF = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_W-1:0]      adc_data,
   input  logic signed [DATA_W:0] offset,
   input  logic [DATA_W-1:0]      trip_level,
   input  logic                   trip_clear,
   input  logic                   peak_clear,
   output logic signed [DATA_W:0] sample_out,
   output logic                   sample_valid,
   output logic                   over_current,
   output logic                   zc_pulse,
   output logic                   zc_polarity,
   output logic [DATA_W-1:0]      peak_mag
);

   localparam int unsigned CORR_W = corr_width(DATA_W);
   localparam int unsigned CONV_W = DATA_W + 2;
   localparam int unsigned TRIP_W = $clog2(TRIP_COUNT + 1);
   localparam int unsigned HO_W   = (ZC_HOLDOFF > 0) ? $clog2(ZC_HOLDOFF + 1) : 1;

   localparam logic signed [CONV_W-1:0] SAT_POS   = CONV_W'(sat_limit(DATA_W));
   localparam logic signed [CONV_W-1:0] SAT_NEG   = -SAT_POS;
   localparam logic signed [CORR_W-1:0] ZC_POS_TH = CORR_W'(ZC_HYST);
   localparam logic signed [CORR_W-1:0] ZC_NEG_TH = -ZC_POS_TH;
   localparam logic [TRIP_W-1:0]        TRIP_MAX  = TRIP_W'(TRIP_COUNT);
   localparam logic [HO_W-1:0]          HO_LOAD   = HO_W'(ZC_HOLDOFF);

   logic [DATA_W-1:0]        adc_q;
   logic                     adc_valid_q;
   logic signed [CONV_W-1:0] conv_c;
   logic signed [CONV_W-1:0] diff_c;
   logic signed [CORR_W-1:0] corr_c;
   logic signed [CORR_W-1:0] corr_q;
   logic                     corr_valid_q;
   logic [DATA_W-1:0]        corr_mag_c;
   logic [DATA_W-1:0]        sample_mag_c;
   logic [TRIP_W-1:0]        trip_cnt;

   zc_state_t                zc_state;
   zc_state_t                zc_state_n;
   logic [HO_W-1:0]          holdoff;
   logic [HO_W-1:0]          holdoff_n;
   logic                     zc_pulse_n;
   logic                     zc_polarity_n;
   logic                     above_c;
   logic                     below_c;

   // Offset binary to two's complement, then clamp the calibrated value symmetrically
   always_comb begin
      conv_c = CONV_W'($signed({~adc_q[DATA_W-1], adc_q[DATA_W-2:0]}));
      diff_c = conv_c - CONV_W'(offset);
      if (diff_c > SAT_POS)      corr_c = CORR_W'(SAT_POS);
      else if (diff_c < SAT_NEG) corr_c = CORR_W'(SAT_NEG);
      else                       corr_c = CORR_W'(diff_c);
      corr_mag_c   = corr_c[CORR_W-1] ? DATA_W'(-corr_c) : DATA_W'(corr_c);
      sample_mag_c = sample_out[CORR_W-1] ? DATA_W'(-sample_out) : DATA_W'(sample_out);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adc_q        <= '0;
         adc_valid_q  <= 1'b0;
         corr_q       <= '0;
         corr_valid_q <= 1'b0;
      end else begin
         adc_q        <= adc_data;
         adc_valid_q  <= 1'b1;
         corr_q       <= corr_c;
         corr_valid_q <= adc_valid_q;
      end
   end

   adc_boxcar #(
      .W        (CORR_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_boxcar (
      .clk          (clk),
      .rst          (rst),
      .corr_valid   (corr_valid_q),
      .corr         (corr_q),
      .sample       (sample_out),
      .sample_valid (sample_valid)
   );

   // Trip counter runs on the unfiltered sample; a set in the same cycle as a clear wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trip_cnt     <= '0;
         over_current <= 1'b0;
      end else begin
         if (adc_valid_q) begin
            if (corr_mag_c > trip_level) begin
               if (trip_cnt != TRIP_MAX) trip_cnt <= trip_cnt + TRIP_W'(1);
            end else begin
               trip_cnt <= '0;
            end
         end
         over_current <= (trip_cnt == TRIP_MAX) | (over_current & ~trip_clear);
      end
   end

   assign above_c = sample_out > ZC_POS_TH;
   assign below_c = sample_out < ZC_NEG_TH;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zc_state    <= ZC_UNKNOWN;
         holdoff     <= '0;
         zc_pulse    <= 1'b0;
         zc_polarity <= 1'b0;
      end else begin
         zc_state    <= zc_state_n;
         holdoff     <= holdoff_n;
         zc_pulse    <= zc_pulse_n;
         zc_polarity <= zc_polarity_n;
      end
   end

   // Zero-crossing next state; the holdoff window freezes the state after each pulse
   always_comb begin
      zc_state_n    = zc_state;
      holdoff_n     = (holdoff != '0) ? holdoff - HO_W'(1) : holdoff;
      zc_pulse_n    = 1'b0;
      zc_polarity_n = zc_polarity;
      if (sample_valid && (holdoff == '0)) begin
         case (zc_state)
            ZC_UNKNOWN: begin
               if (above_c)      zc_state_n = ZC_POS;
               else if (below_c) zc_state_n = ZC_NEG;
            end
            ZC_POS: begin
               if (below_c) begin
                  zc_state_n    = ZC_NEG;
                  zc_pulse_n    = 1'b1;
                  zc_polarity_n = 1'b0;
                  holdoff_n     = HO_LOAD;
               end
            end
            ZC_NEG: begin
               if (above_c) begin
                  zc_state_n    = ZC_POS;
                  zc_pulse_n    = 1'b1;
                  zc_polarity_n = 1'b1;
                  holdoff_n     = HO_LOAD;
               end
            end
            default: zc_state_n = ZC_UNKNOWN;
         endcase
      end
   end

   // Peak hold tracks |sample_out| only once the filter window is full
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak_mag <= '0;
      end else if (peak_clear) begin
         peak_mag <= sample_valid ? sample_mag_c : '0;
      end else if (sample_valid && (sample_mag_c > peak_mag)) begin
         peak_mag <= sample_mag_c;
      end
   end

endmodule

// File: tb/tb_adc_frontend.sv
// Directed bench for adc_frontend: default build plus an unfiltered, short-holdoff build.
module tb_adc_frontend;

   logic               clk;
   logic               rst;
   logic [9:0]         adc_data;
   logic signed [10:0] offset;
   logic [9:0]         trip_level;
   logic               trip_clear;
   logic               peak_clear;

   logic signed [10:0] sample_out;
   logic               sample_valid;
   logic               over_current;
   logic               zc_pulse;
   logic               zc_polarity;
   logic [9:0]         peak_mag;

   logic signed [10:0] zsample_out;
   logic               zsample_valid;
   logic               zover_current;
   logic               zzc_pulse;
   logic               zzc_polarity;
   logic [9:0]         zpeak_mag;

   int checks = 0;
   int errors = 0;

   adc_frontend dut (
      .clk          (clk),
      .rst          (rst),
      .adc_data     (adc_data),
      .offset       (offset),
      .trip_level   (trip_level),
      .trip_clear   (trip_clear),
      .peak_clear   (peak_clear),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .over_current (over_current),
      .zc_pulse     (zc_pulse),
      .zc_polarity  (zc_polarity),
      .peak_mag     (peak_mag)
   );

   adc_frontend #(
      .AVG_LOG2   (0),
      .ZC_HOLDOFF (4)
   ) dut_zc (
      .clk          (clk),
      .rst          (rst),
      .adc_data     (adc_data),
      .offset       (offset),
      .trip_level   (trip_level),
      .trip_clear   (trip_clear),
      .peak_clear   (peak_clear),
      .sample_out   (zsample_out),
      .sample_valid (zsample_valid),
      .over_current (zover_current),
      .zc_pulse     (zzc_pulse),
      .zc_polarity  (zzc_polarity),
      .peak_mag     (zpeak_mag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sample_out"}, sample_out, 0);
      check({tag, "_sample_valid"}, sample_valid, 0);
      check({tag, "_over_current"}, over_current, 0);
      check({tag, "_zc_pulse"}, zc_pulse, 0);
      check({tag, "_zc_polarity"}, zc_polarity, 0);
      check({tag, "_peak_mag"}, peak_mag, 0);
   endtask

   // Four fill samples after release: valid exactly on the sixth edge
   task automatic check_fill(input string tag);
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 5) check({tag, "_valid_early"}, sample_valid, 0);
         if (i == 6) check({tag, "_valid_rise"}, sample_valid, 1);
      end
      check({tag, "_sample_300"}, sample_out, 300);
   endtask

   initial begin
      int pulses;
      int last_pulse;
      int gap_bad;

      rst        = 1'b1;
      adc_data   = 10'd812;
      offset     = '0;
      trip_level = 10'd1023;
      trip_clear = 1'b0;
      peak_clear = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");

      // Steady 812 -> corr 300
      rst = 1'b0;
      check_fill("fill");
      tick();
      check("peak_300", peak_mag, 300);

      // Step to 962 (corr 450): floor averages of the mixed window
      adc_data = 10'd962;
      repeat (3) tick();
      check("ramp_337", sample_out, 337);
      tick();
      check("ramp_375", sample_out, 375);
      tick();
      check("ramp_412", sample_out, 412);
      tick();
      check("ramp_450", sample_out, 450);
      tick();
      check("peak_450", peak_mag, 450);

      // Over-current: two over-level samples must not trip, three must
      adc_data = 10'd812;
      repeat (3) tick();
      trip_level = 10'd400;
      repeat (2) tick();
      for (int i = 0; i < 2; i++) begin
         adc_data = 10'd962;
         tick();
      end
      adc_data = 10'd812;
      repeat (4) tick();
      check("trip_two_samples", over_current, 0);
      for (int i = 0; i < 3; i++) begin
         adc_data = 10'd962;
         tick();
      end
      tick();
      check("trip_count_reached", over_current, 0);
      tick();
      check("trip_set", over_current, 1);
      trip_clear = 1'b1;
      tick();
      trip_clear = 1'b0;
      check("trip_set_beats_clear", over_current, 1);
      adc_data = 10'd812;
      repeat (3) tick();
      check("trip_latched", over_current, 1);
      trip_clear = 1'b1;
      tick();
      trip_clear = 1'b0;
      check("trip_cleared", over_current, 0);

      // Async reset mid-stream with the trip latched and peak held
      for (int i = 0; i < 3; i++) begin
         adc_data = 10'd962;
         tick();
      end
      repeat (2) tick();
      check("pre_rst_trip", over_current, 1);
      check("pre_rst_peak", peak_mag, 450);
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      adc_data   = 10'd812;
      trip_level = 10'd1023;
      repeat (2) tick();
      rst = 1'b0;
      check_fill("refill");

      // Saturation both ways; |corr| equal to trip_level is not over level
      offset   = -11'sd600;
      adc_data = 10'd1023;
      repeat (8) tick();
      check("sat_pos", sample_out, 1023);
      check("sat_pos_peak", peak_mag, 1023);
      check("trip_at_level", over_current, 0);
      offset   = 11'sd600;
      adc_data = 10'd0;
      repeat (8) tick();
      check("sat_neg", sample_out, -1023);
      check("sat_neg_peak", peak_mag, 1023);
      peak_clear = 1'b1;
      tick();
      peak_clear = 1'b0;
      check("peak_clear_load", peak_mag, 1023);

      // Zero crossing on the unfiltered build: +/-100 every 8 cycles
      rst      = 1'b1;
      offset   = '0;
      adc_data = 10'd612;
      repeat (2) tick();
      rst = 1'b0;
      for (int seg = 0; seg < 6; seg++) begin
         adc_data = (seg % 2 == 0) ? 10'd612 : 10'd412;
         for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("zc_pulse_s%0d_c%0d", seg, i), zzc_pulse,
                  (seg > 0 && i == 4) ? 1 : 0);
            if (seg > 0 && i == 4)
               check($sformatf("zc_pol_s%0d", seg), zzc_polarity, (seg % 2 == 0) ? 1 : 0);
         end
         check($sformatf("zc_sample_s%0d", seg), zsample_out, (seg % 2 == 0) ? 100 : -100);
      end

      // Toggling every 2 cycles: holdoff of 4 leaves one pulse per 6 cycles
      pulses     = 0;
      last_pulse = -100;
      gap_bad    = 0;
      for (int j = 0; j < 12; j++) begin
         adc_data = (j % 2 == 0) ? 10'd612 : 10'd412;
         for (int k = 0; k < 2; k++) begin
            tick();
            if (zzc_pulse) begin
               if (2 * j + k - last_pulse < 5) gap_bad = 1;
               last_pulse = 2 * j + k;
               pulses++;
            end
         end
      end
      check("zc_fast_pulses", pulses, 4);
      check("zc_fast_gap", gap_bad, 0);
      check("zc_fast_pol", zzc_polarity, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

endmodule
